// File: rtl/mem_req_scheduler_pkg.sv
// ============================================================
// mem_req_scheduler_pkg : shared types and widths for the scheduler
// Revision: 1.0
// ============================================================
`default_nettype none

package mem_req_scheduler_pkg;

  localparam int ADDR_W   = 30;
  localparam int RLEN_W   = 5;
  localparam int CMD_ID_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // id is sized for the largest supported port count; the top uses the low ID_W bits
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [RLEN_W-1:0]   rlen;
    logic                rnw;
    logic [CMD_ID_W-1:0] id;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_scheduler_rr_select.sv
// ============================================================
// rr_select : first asserted request at or after rr_ptr, wrapping
// Revision: 1.0
// ============================================================
`default_nettype none

module rr_select #(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 2
) (
  input  logic [NUM_PORTS-1:0] requests,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic [ID_W-1:0]      grantee,
  output logic                 any
);

  int w_idx;

  always_comb begin
    grantee = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!any && requests[w_idx]) begin
        any     = 1'b1;
        grantee = ID_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_scheduler.sv
// ============================================================
// mem_req_scheduler : round-robin arbiter issuing one memory command
// at a time and routing returned read beats back by ID
// Revision: 1.0
// ============================================================
`default_nettype none

module mem_req_scheduler
  import mem_req_scheduler_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_PORTS-1:0][RLEN_W-1:0]    req_rlen,
  input  logic [NUM_PORTS-1:0]                req_rnw,
  output logic [NUM_PORTS-1:0]                req_ack,
  output logic [NUM_PORTS-1:0]                rvalid,
  output logic [NUM_PORTS-1:0]                rlast,
  output logic [NUM_PORTS-1:0]                busy,
  output logic                                mem_request,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [RLEN_W-1:0]                   mem_rlen,
  output logic                                mem_rnw,
  output logic [ID_W-1:0]                     mem_id,
  input  logic                                mem_ack,
  input  logic                                mem_rvalid,
  input  logic [ID_W-1:0]                     mem_rid
);

  state_t                           r_state;
  cmd_t                             r_cmd;
  logic                             r_mem_request;
  logic [ID_W-1:0]                  r_rr_ptr;
  logic [NUM_PORTS-1:0]             r_busy;
  logic [NUM_PORTS-1:0][RLEN_W-1:0] r_beat_cnt;

  logic [NUM_PORTS-1:0] w_eligible;
  logic [ID_W-1:0]      w_grantee;
  logic                 w_any;
  logic                 w_accept;
  logic [ID_W-1:0]      w_next_ptr;

  assign w_eligible = req & ~r_busy;
  assign w_accept   = (r_state == ST_ISSUE) && mem_ack;
  assign w_next_ptr = (r_cmd.id == CMD_ID_W'(NUM_PORTS - 1)) ? '0 : ID_W'(r_cmd.id + 1'b1);

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_rr_select (
    .requests (w_eligible),
    .rr_ptr   (r_rr_ptr),
    .grantee  (w_grantee),
    .any      (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_mem_request <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_cmd.addr    <= req_addr[w_grantee];
            r_cmd.rlen    <= req_rlen[w_grantee];
            r_cmd.rnw     <= req_rnw[w_grantee];
            r_cmd.id      <= CMD_ID_W'(w_grantee);
            r_mem_request <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ack) begin
            r_mem_request <= 1'b0;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A read accept on a port overrides a final beat on the same port in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_beat_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (mem_rvalid && r_busy[p] && (mem_rid == ID_W'(p))) begin
          if (r_beat_cnt[p] == '0) r_busy[p] <= 1'b0;
          else                     r_beat_cnt[p] <= r_beat_cnt[p] - 1'b1;
        end
        if (w_accept && r_cmd.rnw && (mem_id == ID_W'(p))) begin
          r_busy[p]     <= 1'b1;
          r_beat_cnt[p] <= r_cmd.rlen;
        end
      end
    end
  end

  always_comb begin
    req_ack = '0;
    rvalid  = '0;
    rlast   = '0;
    if (w_accept) req_ack[mem_id] = 1'b1;
    if (mem_rvalid && r_busy[mem_rid]) begin
      rvalid[mem_rid] = 1'b1;
      rlast[mem_rid]  = (r_beat_cnt[mem_rid] == '0);
    end
  end

  assign busy        = r_busy;
  assign mem_request = r_mem_request;
  assign mem_addr    = r_cmd.addr;
  assign mem_rlen    = r_cmd.rlen;
  assign mem_rnw     = r_cmd.rnw;
  assign mem_id      = r_cmd.id[ID_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_mem_req_scheduler.sv
// ============================================================
// tb_mem_req_scheduler : random requesters and memory against a
// transaction-level model of arbitration and read-beat return
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_mem_req_scheduler;

  localparam int NP = 4;
  localparam int IW = 2;

  logic                 clk;
  logic                 rst;
  logic [NP-1:0]        req;
  logic [NP-1:0][29:0]  req_addr;
  logic [NP-1:0][4:0]   req_rlen;
  logic [NP-1:0]        req_rnw;
  logic [NP-1:0]        req_ack;
  logic [NP-1:0]        rvalid;
  logic [NP-1:0]        rlast;
  logic [NP-1:0]        busy;
  logic                 mem_request;
  logic [29:0]          mem_addr;
  logic [4:0]           mem_rlen;
  logic                 mem_rnw;
  logic [IW-1:0]        mem_id;
  logic                 mem_ack;
  logic                 mem_rvalid;
  logic [IW-1:0]        mem_rid;

  mem_req_scheduler #(.NUM_PORTS(NP), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_rlen    (req_rlen),
    .req_rnw     (req_rnw),
    .req_ack     (req_ack),
    .rvalid      (rvalid),
    .rlast       (rlast),
    .busy        (busy),
    .mem_request (mem_request),
    .mem_addr    (mem_addr),
    .mem_rlen    (mem_rlen),
    .mem_rnw     (mem_rnw),
    .mem_id      (mem_id),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rid     (mem_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester side
  bit        pend [NP];
  bit [29:0] p_addr [NP];
  bit [4:0]  p_rlen [NP];
  bit        p_rnw [NP];

  // model: one command outstanding, per-port beats still owed
  bit        m_hold;
  int        m_ptr;
  bit [29:0] m_addr;
  bit [4:0]  m_rlen;
  bit        m_rnw;
  int        m_id;
  bit        m_busy [NP];
  int        m_left [NP];

  function automatic logic [NP-1:0] busy_vec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = m_busy[p];
    return v;
  endfunction

  task automatic model_clear();
    m_hold = 0;
    m_ptr  = 0;
    for (int p = 0; p < NP; p++) begin
      m_busy[p] = 0;
      m_left[p] = 0;
      pend[p]   = 0;
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < NP; p++) begin
      req[p]      = pend[p];
      req_addr[p] = p_addr[p];
      req_rlen[p] = p_rlen[p];
      req_rnw[p]  = p_rnw[p];
    end
  endtask

  task automatic check_all_zero(input string where);
    check_eq({where, ".mem_request"}, 64'(mem_request), 64'd0);
    check_eq({where, ".req_ack"},     64'(req_ack),     64'd0);
    check_eq({where, ".rvalid"},      64'(rvalid),      64'd0);
    check_eq({where, ".rlast"},       64'(rlast),       64'd0);
    check_eq({where, ".busy"},        64'(busy),        64'd0);
    check_eq({where, ".mem_addr"},    64'(mem_addr),    64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    drive_ports();
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_cycle();
    logic [NP-1:0] e_ack, e_rv, e_rl;
    int rid;
    e_ack = '0; e_rv = '0; e_rl = '0;
    rid = int'(mem_rid);
    if (m_hold && mem_ack) e_ack[m_id] = 1'b1;
    if (mem_rvalid && m_busy[rid]) begin
      e_rv[rid] = 1'b1;
      e_rl[rid] = (m_left[rid] == 0);
    end
    check_eq("mem_request", 64'(mem_request), 64'(m_hold));
    check_eq("busy",        64'(busy),        64'(busy_vec()));
    check_eq("req_ack",     64'(req_ack),     64'(e_ack));
    check_eq("rvalid",      64'(rvalid),      64'(e_rv));
    check_eq("rlast",       64'(rlast),       64'(e_rl));
    if (m_hold) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
      check_eq("mem_rlen", 64'(mem_rlen), 64'(m_rlen));
      check_eq("mem_rnw",  64'(mem_rnw),  64'(m_rnw));
      check_eq("mem_id",   64'(mem_id),   64'(m_id));
    end
  endtask

  // Advance the model by one clock edge using the inputs seen this cycle
  task automatic model_step();
    bit snap_busy [NP];
    bit was_hold;
    int rid;
    for (int p = 0; p < NP; p++) snap_busy[p] = m_busy[p];
    was_hold = m_hold;
    rid = int'(mem_rid);
    if (mem_rvalid && m_busy[rid]) begin
      if (m_left[rid] == 0) m_busy[rid] = 0;
      else                  m_left[rid] = m_left[rid] - 1;
    end
    if (was_hold) begin
      if (mem_ack) begin
        m_hold     = 0;
        m_ptr      = (m_id + 1) % NP;
        pend[m_id] = 0;
        if (m_rnw) begin
          m_busy[m_id] = 1;
          m_left[m_id] = m_rlen;
        end
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        int p;
        p = (m_ptr + i) % NP;
        if (!m_hold && req[p] && !snap_busy[p]) begin
          m_hold = 1;
          m_id   = p;
          m_addr = req_addr[p];
          m_rlen = req_rlen[p];
          m_rnw  = req_rnw[p];
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rid    = '0;
    for (int p = 0; p < NP; p++) begin
      p_addr[p] = '0; p_rlen[p] = '0; p_rnw[p] = 1'b0;
    end
    model_clear();
    drive_ports();
    @(negedge clk);
    check_all_zero("init");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // phase 0: mixed traffic with stalls, stray beats and occasional resets
    // phase 1: every port writing, memory always ready
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        @(posedge clk);
        #1;
        do_reset();
      end
      for (int cyc = 0; cyc < 2500; cyc++) begin
        @(posedge clk);
        #1;
        if (phase == 0 && $urandom_range(0, 299) == 0) begin
          mem_rvalid = 1'b1;
          do_reset();
          continue;
        end
        for (int p = 0; p < NP; p++) begin
          if (phase == 1) begin
            pend[p] = 1; p_rnw[p] = 1'b0; p_addr[p] = 30'($urandom); p_rlen[p] = 5'($urandom);
          end else if (!pend[p] && $urandom_range(0, 3) == 0) begin
            pend[p]   = 1;
            p_addr[p] = 30'($urandom);
            p_rlen[p] = 5'($urandom_range(0, 7));
            p_rnw[p]  = 1'($urandom);
          end else if (pend[p] && $urandom_range(0, 2) == 0) begin
            p_addr[p] = 30'($urandom);
          end
        end
        drive_ports();
        mem_ack    = (phase == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
        mem_rvalid = 1'($urandom);
        mem_rid    = IW'($urandom);
        @(negedge clk);
        check_cycle();
        model_step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
